// File: rtl/code_wp_pkg.sv
// Shared types and constants for the code write-protect controller.
//   cfg_op_e   : 3-bit config opcode (5..7 illegal)
//   wp_state_e : controller FSM state
//   KEY*_DEF   : default unlock keys
package code_wp_pkg;

  localparam int unsigned OP_W   = 3;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned ADDR_W = 32;
  localparam int unsigned TMR_W  = 32;

  localparam logic [DATA_W-1:0] KEY0_DEF = 32'hC0DE_5AFE;
  localparam logic [DATA_W-1:0] KEY1_DEF = 32'h5AFE_C0DE;

  typedef enum logic [OP_W-1:0] {
    OP_KEY      = 3'd0,
    OP_CLOSE    = 3'd1,
    OP_SET_WP   = 3'd2,
    OP_SET_LOCK = 3'd3,
    OP_CLR_VIOL = 3'd4
  } cfg_op_e;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_KEYWAIT = 3'd1,
    ST_UPDATE  = 3'd2,
    ST_PROTECT = 3'd3,
    ST_LOCKED  = 3'd4
  } wp_state_e;

endpackage

// File: rtl/code_wp_ctrl_if.sv
// Boot ROM config port: op request/ready handshake plus one-cycle response.
//   master : drives cfg_valid/cfg_op/cfg_data/cfg_priv, receives ready/response
//   slave  : the controller side
interface code_wp_ctrl_if;
  import code_wp_pkg::*;

  logic              cfg_valid;
  logic              cfg_ready;
  logic [OP_W-1:0]   cfg_op;
  logic [DATA_W-1:0] cfg_data;
  logic              cfg_priv;
  logic              cfg_resp_valid;
  logic              cfg_resp_err;

  modport master (
    output cfg_valid, cfg_op, cfg_data, cfg_priv,
    input  cfg_ready, cfg_resp_valid, cfg_resp_err
  );

  modport slave (
    input  cfg_valid, cfg_op, cfg_data, cfg_priv,
    output cfg_ready, cfg_resp_valid, cfg_resp_err
  );
endinterface

// File: rtl/code_wp_viol_log.sv
// Violation log fed by the guard's deny strobe.
//   clk, rst      : clock, synchronous active-high reset
//   deny_i        : guard blocked a write this cycle
//   deny_addr_i   : address of the blocked write
//   i_clr         : clear strobe (accepted CLR_VIOL)
//   o_cnt         : saturating deny count
//   o_addr        : first denied address since last clear
//   o_irq         : level interrupt, set on deny
module code_wp_viol_log
  import code_wp_pkg::*;
#(
  parameter int unsigned VCNT_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              deny_i,
  input  logic [ADDR_W-1:0] deny_addr_i,
  input  logic              i_clr,
  output logic [VCNT_W-1:0] o_cnt,
  output logic [ADDR_W-1:0] o_addr,
  output logic              o_irq
);

  logic [VCNT_W-1:0] r_cnt;
  logic [ADDR_W-1:0] r_addr;
  logic              r_irq;

  // A deny in the same cycle as a clear wins: the log restarts at this deny.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt  <= '0;
      r_addr <= '0;
      r_irq  <= 1'b0;
    end else if (deny_i) begin
      if (i_clr || (r_cnt == '0)) r_addr <= deny_addr_i;
      if (i_clr)                  r_cnt  <= VCNT_W'(1);
      else if (r_cnt != '1)       r_cnt  <= r_cnt + VCNT_W'(1);
      r_irq <= 1'b1;
    end else if (i_clr) begin
      r_cnt  <= '0;
      r_addr <= '0;
      r_irq  <= 1'b0;
    end
  end

  assign o_cnt  = r_cnt;
  assign o_addr = r_addr;
  assign o_irq  = r_irq;

endmodule

// File: rtl/code_wp_ctrl.sv
// Code write-protect controller: two-key unlock, timed update window,
// sticky WP/LOCK escalation and violation log.
//   clk, rst     : clock, synchronous active-high reset
//   cfg          : config op port (slave)
//   deny_i       : guard deny strobe, deny_addr_i its address
//   update_en_o  : update window open
//   wp_o, lock_o : sticky write-protect / system lock
//   viol_*_o     : violation count, first address, irq
module code_wp_ctrl
  import code_wp_pkg::*;
#(
  parameter int unsigned       UPD_TIMEOUT = 1_000_000,
  parameter logic [DATA_W-1:0] KEY0        = KEY0_DEF,
  parameter logic [DATA_W-1:0] KEY1        = KEY1_DEF,
  parameter int unsigned       VCNT_W      = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  code_wp_ctrl_if.slave        cfg,
  input  logic                 deny_i,
  input  logic [ADDR_W-1:0]    deny_addr_i,
  output logic                 update_en_o,
  output logic                 wp_o,
  output logic                 lock_o,
  output logic [VCNT_W-1:0]    viol_cnt_o,
  output logic [ADDR_W-1:0]    viol_addr_o,
  output logic                 viol_irq_o
);

  wp_state_e        r_state;
  wp_state_e        w_state_nxt;
  logic [TMR_W-1:0] r_timer;
  logic             r_ready;
  logic             r_resp_valid;
  logic             r_resp_err;
  logic             r_update_en;
  logic             r_wp;
  logic             r_lock;
  logic             w_accept;
  logic             w_err;
  logic             w_clr;
  cfg_op_e          w_op;

  assign w_accept = cfg.cfg_valid & r_ready;
  assign w_op     = cfg_op_e'(cfg.cfg_op);

  // Next-state and response decode for an accepted op, then window timeout.
  always_comb begin
    w_state_nxt = r_state;
    w_err       = 1'b0;
    w_clr       = 1'b0;
    if (w_accept) begin
      if (w_op == OP_CLR_VIOL) begin
        w_clr = 1'b1;
      end else if (!cfg.cfg_priv) begin
        w_err = 1'b1;
      end else begin
        unique case (r_state)
          ST_IDLE: begin
            case (w_op)
              OP_KEY: begin
                if (cfg.cfg_data == KEY0) w_state_nxt = ST_KEYWAIT;
                else                      w_err       = 1'b1;
              end
              OP_CLOSE:    ;
              OP_SET_WP:   w_state_nxt = ST_PROTECT;
              OP_SET_LOCK: w_state_nxt = ST_LOCKED;
              default:     w_err = 1'b1;
            endcase
          end
          ST_KEYWAIT: begin
            case (w_op)
              OP_KEY: begin
                if (cfg.cfg_data == KEY1) begin
                  w_state_nxt = ST_UPDATE;
                end else begin
                  w_err       = 1'b1;
                  w_state_nxt = ST_IDLE;
                end
              end
              OP_CLOSE, OP_SET_WP, OP_SET_LOCK: begin
                w_err       = 1'b1;
                w_state_nxt = ST_IDLE;
              end
              default: w_err = 1'b1;
            endcase
          end
          ST_UPDATE: begin
            case (w_op)
              OP_CLOSE:    w_state_nxt = ST_IDLE;
              OP_SET_WP:   w_state_nxt = ST_PROTECT;
              OP_SET_LOCK: w_state_nxt = ST_LOCKED;
              default:     w_err = 1'b1;
            endcase
          end
          ST_PROTECT: begin
            case (w_op)
              OP_SET_LOCK: w_state_nxt = ST_LOCKED;
              OP_SET_WP:   ;
              default:     w_err = 1'b1;
            endcase
          end
          ST_LOCKED: begin
            if (w_op != OP_SET_LOCK) w_err = 1'b1;
          end
          default: w_state_nxt = ST_IDLE;
        endcase
      end
    end
    // Every accepted transition leaves UPDATE, so staying means the window expires.
    if ((r_state == ST_UPDATE) && (w_state_nxt == ST_UPDATE) && (r_timer == '0))
      w_state_nxt = ST_IDLE;
  end

  // State, window timer, handshake and state-decoded outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_timer      <= '0;
      r_ready      <= 1'b1;
      r_resp_valid <= 1'b0;
      r_resp_err   <= 1'b0;
      r_update_en  <= 1'b0;
      r_wp         <= 1'b0;
      r_lock       <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_ready      <= ~w_accept;
      r_resp_valid <= w_accept;
      r_resp_err   <= w_accept & w_err;
      r_update_en  <= (w_state_nxt == ST_UPDATE);
      r_wp         <= (w_state_nxt == ST_PROTECT) || (w_state_nxt == ST_LOCKED);
      r_lock       <= (w_state_nxt == ST_LOCKED);
      if (w_state_nxt != ST_UPDATE)  r_timer <= '0;
      else if (r_state != ST_UPDATE) r_timer <= TMR_W'(UPD_TIMEOUT - 1);
      else                           r_timer <= r_timer - TMR_W'(1);
    end
  end

  assign cfg.cfg_ready      = r_ready;
  assign cfg.cfg_resp_valid = r_resp_valid;
  assign cfg.cfg_resp_err   = r_resp_err;
  assign update_en_o        = r_update_en;
  assign wp_o               = r_wp;
  assign lock_o             = r_lock;

  code_wp_viol_log #(
    .VCNT_W (VCNT_W)
  ) u_viol_log (
    .clk         (clk),
    .rst         (rst),
    .deny_i      (deny_i),
    .deny_addr_i (deny_addr_i),
    .i_clr       (w_clr),
    .o_cnt       (viol_cnt_o),
    .o_addr      (viol_addr_o),
    .o_irq       (viol_irq_o)
  );

endmodule

// File: tb/tb_code_wp_ctrl.sv
// Directed bench for code_wp_ctrl (UPD_TIMEOUT=8, VCNT_W=2).
module tb_code_wp_ctrl;
  import code_wp_pkg::*;

  localparam int unsigned TO = 8;
  localparam int unsigned VW = 2;

  logic          clk;
  logic          rst;
  logic          deny;
  logic [31:0]   deny_addr;
  logic          upd_en, wp, lock, irq;
  logic [VW-1:0] vcnt;
  logic [31:0]   vaddr;

  int errors = 0;
  int checks = 0;

  code_wp_ctrl_if cfg_if ();

  code_wp_ctrl #(.UPD_TIMEOUT(TO), .VCNT_W(VW)) dut (
    .clk(clk), .rst(rst), .cfg(cfg_if), .deny_i(deny), .deny_addr_i(deny_addr),
    .update_en_o(upd_en), .wp_o(wp), .lock_o(lock),
    .viol_cnt_o(vcnt), .viol_addr_o(vaddr), .viol_irq_o(irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Issue one op; returns response seen in the cycle after acceptance.
  task automatic do_op(input logic [2:0] op, input logic [31:0] data, input logic priv,
                       output logic got, output logic err, output logic rdy);
    int n;
    @(negedge clk);
    n = 0;
    while (cfg_if.cfg_ready !== 1'b1 && n < 8) begin @(negedge clk); n++; end
    cfg_if.cfg_valid = 1'b1; cfg_if.cfg_op = op; cfg_if.cfg_data = data; cfg_if.cfg_priv = priv;
    @(negedge clk);
    got = cfg_if.cfg_resp_valid; err = cfg_if.cfg_resp_err; rdy = cfg_if.cfg_ready;
    cfg_if.cfg_valid = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
  endtask

  task automatic test_reset();
    checks++; if (cfg_if.cfg_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got=%b exp=1", cfg_if.cfg_ready); end
    checks++; if (cfg_if.cfg_resp_valid !== 1'b0) begin errors++; $display("FAIL reset_resp got=%b exp=0", cfg_if.cfg_resp_valid); end
    checks++; if ({upd_en, wp, lock, irq} !== 4'b0) begin errors++; $display("FAIL reset_state got=%b exp=0000", {upd_en, wp, lock, irq}); end
    checks++; if (vcnt !== 2'd0 || vaddr !== 32'd0) begin errors++; $display("FAIL reset_viol cnt=%0d addr=%h exp 0/0", vcnt, vaddr); end
  endtask

  task automatic test_unlock();
    logic g, e, r; int n;
    do_op(3'd0, 32'hC0DE_5AFE, 1'b1, g, e, r);
    checks++; if ({g, e, upd_en} !== 3'b100) begin errors++; $display("FAIL unlock_key0 got v/e/upd=%b exp=100", {g, e, upd_en}); end
    do_op(3'd0, 32'h5AFE_C0DE, 1'b1, g, e, r);
    checks++; if ({g, e, upd_en} !== 3'b101) begin errors++; $display("FAIL unlock_key1 got v/e/upd=%b exp=101", {g, e, upd_en}); end
    n = 1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (upd_en === 1'b1) n++; else break;
    end
    checks++; if (n !== 8) begin errors++; $display("FAIL unlock_window got=%0d exp=8 cycles", n); end
    checks++; if ({upd_en, wp, lock} !== 3'b000) begin errors++; $display("FAIL unlock_expire got=%b exp=000", {upd_en, wp, lock}); end
  endtask

  task automatic test_bad_key();
    logic g, e, r;
    do_op(3'd0, 32'hC0DE_5AFE, 1'b1, g, e, r);
    do_op(3'd0, 32'h1234_5678, 1'b1, g, e, r);
    checks++; if ({g, e, upd_en} !== 3'b110) begin errors++; $display("FAIL badkey_resp got v/e/upd=%b exp=110", {g, e, upd_en}); end
    // Back in IDLE, KEY1 alone is a wrong key
    do_op(3'd0, 32'h5AFE_C0DE, 1'b1, g, e, r);
    checks++; if ({g, e, upd_en} !== 3'b110) begin errors++; $display("FAIL badkey_idle got v/e/upd=%b exp=110", {g, e, upd_en}); end
  endtask

  task automatic test_escalation();
    logic g, e, r;
    do_op(3'd0, 32'hC0DE_5AFE, 1'b1, g, e, r);
    do_op(3'd0, 32'h5AFE_C0DE, 1'b1, g, e, r);
    do_op(3'd2, 32'h0, 1'b1, g, e, r);
    checks++; if ({g, e, upd_en, wp, lock} !== 5'b10010) begin errors++; $display("FAIL esc_setwp got=%b exp=10010", {g, e, upd_en, wp, lock}); end
    do_op(3'd0, 32'hC0DE_5AFE, 1'b1, g, e, r);
    checks++; if ({g, e, wp} !== 3'b111) begin errors++; $display("FAIL esc_key got=%b exp=111", {g, e, wp}); end
    do_op(3'd3, 32'h0, 1'b1, g, e, r);
    checks++; if ({g, e, upd_en, wp, lock} !== 5'b10011) begin errors++; $display("FAIL esc_setlock got=%b exp=10011", {g, e, upd_en, wp, lock}); end
    do_op(3'd1, 32'h0, 1'b1, g, e, r);
    checks++; if ({g, e, lock} !== 3'b111) begin errors++; $display("FAIL esc_close got=%b exp=111", {g, e, lock}); end
    do_reset();
  endtask

  task automatic test_priv_illegal();
    logic g, e, r;
    do_op(3'd3, 32'h0, 1'b0, g, e, r);
    checks++; if ({g, e, wp, lock} !== 4'b1100) begin errors++; $display("FAIL priv_setlock got=%b exp=1100", {g, e, wp, lock}); end
    do_op(3'd4, 32'h0, 1'b0, g, e, r);
    checks++; if ({g, e} !== 2'b10) begin errors++; $display("FAIL priv_clrviol got=%b exp=10", {g, e}); end
    do_op(3'd5, 32'h0, 1'b1, g, e, r);
    checks++; if ({g, e, upd_en, wp, lock} !== 5'b11000) begin errors++; $display("FAIL illegal_op got=%b exp=11000", {g, e, upd_en, wp, lock}); end
  endtask

  task automatic test_violations();
    logic g, e, r;
    @(negedge clk); deny = 1'b1; deny_addr = 32'h100;
    @(negedge clk); deny = 1'b0;
    checks++; if ({vcnt, irq} !== 3'b011 || vaddr !== 32'h100) begin errors++; $display("FAIL viol_first cnt=%0d irq=%b addr=%h exp 1/1/100", vcnt, irq, vaddr); end
    deny = 1'b1; deny_addr = 32'h200;
    @(negedge clk); deny = 1'b0;
    checks++; if ({vcnt, irq} !== 3'b101 || vaddr !== 32'h100) begin errors++; $display("FAIL viol_second cnt=%0d irq=%b addr=%h exp 2/1/100", vcnt, irq, vaddr); end
    // Clear coincident with a deny: deny wins
    @(negedge clk);
    cfg_if.cfg_valid = 1'b1; cfg_if.cfg_op = 3'd4; cfg_if.cfg_priv = 1'b1;
    deny = 1'b1; deny_addr = 32'h300;
    @(negedge clk);
    cfg_if.cfg_valid = 1'b0; deny = 1'b0;
    checks++; if ({cfg_if.cfg_resp_valid, cfg_if.cfg_resp_err} !== 2'b10) begin errors++; $display("FAIL viol_clr_resp got=%b exp=10", {cfg_if.cfg_resp_valid, cfg_if.cfg_resp_err}); end
    checks++; if ({vcnt, irq} !== 3'b011 || vaddr !== 32'h300) begin errors++; $display("FAIL viol_clr_deny cnt=%0d irq=%b addr=%h exp 1/1/300", vcnt, irq, vaddr); end
    deny = 1'b1; deny_addr = 32'h400;
    repeat (3) @(negedge clk);
    deny = 1'b0;
    checks++; if (vcnt !== 2'd3 || vaddr !== 32'h300) begin errors++; $display("FAIL viol_sat cnt=%0d addr=%h exp 3/300", vcnt, vaddr); end
    do_op(3'd4, 32'h0, 1'b1, g, e, r);
    checks++; if ({e, vcnt, irq} !== 4'b0000 || vaddr !== 32'h0) begin errors++; $display("FAIL viol_clear err=%b cnt=%0d irq=%b addr=%h exp 0/0/0/0", e, vcnt, irq, vaddr); end
  endtask

  task automatic test_boundary();
    logic g, e, r;
    do_op(3'd0, 32'hC0DE_5AFE, 1'b1, g, e, r);
    do_op(3'd0, 32'h5AFE_C0DE, 1'b1, g, e, r);
    repeat (6) @(negedge clk);
    checks++; if (upd_en !== 1'b1) begin errors++; $display("FAIL bnd_still_open got=%b exp=1", upd_en); end
    do_op(3'd3, 32'h0, 1'b1, g, e, r);
    checks++; if ({g, e, upd_en, wp, lock} !== 5'b10011) begin errors++; $display("FAIL bnd_setlock got=%b exp=10011", {g, e, upd_en, wp, lock}); end
    do_reset();
    do_op(3'd0, 32'hC0DE_5AFE, 1'b1, g, e, r);
    do_op(3'd0, 32'h5AFE_C0DE, 1'b1, g, e, r);
    repeat (6) @(negedge clk);
    do_op(3'd1, 32'h0, 1'b1, g, e, r);
    checks++; if ({g, e, upd_en, wp} !== 4'b1000) begin errors++; $display("FAIL bnd_close got=%b exp=1000", {g, e, upd_en, wp}); end
  endtask

  task automatic test_reset_mid();
    logic g, e, r;
    do_op(3'd0, 32'hC0DE_5AFE, 1'b1, g, e, r);
    do_op(3'd0, 32'h5AFE_C0DE, 1'b1, g, e, r);
    @(negedge clk);
    cfg_if.cfg_valid = 1'b1; cfg_if.cfg_op = 3'd2; cfg_if.cfg_priv = 1'b1; rst = 1'b1;
    @(negedge clk);
    cfg_if.cfg_valid = 1'b0; rst = 1'b0;
    checks++; if ({cfg_if.cfg_resp_valid, cfg_if.cfg_ready, upd_en, wp, lock} !== 5'b01000) begin errors++; $display("FAIL rst_mid got=%b exp=01000", {cfg_if.cfg_resp_valid, cfg_if.cfg_ready, upd_en, wp, lock}); end
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    cfg_if.cfg_valid = 1'b1; cfg_if.cfg_op = 3'd0; cfg_if.cfg_data = 32'hC0DE_5AFE; cfg_if.cfg_priv = 1'b1;
    @(negedge clk);
    checks++; if ({cfg_if.cfg_resp_valid, cfg_if.cfg_resp_err, cfg_if.cfg_ready} !== 3'b100) begin errors++; $display("FAIL b2b_first got=%b exp=100", {cfg_if.cfg_resp_valid, cfg_if.cfg_resp_err, cfg_if.cfg_ready}); end
    cfg_if.cfg_data = 32'h5AFE_C0DE;
    @(negedge clk);
    checks++; if ({cfg_if.cfg_resp_valid, cfg_if.cfg_ready} !== 2'b01) begin errors++; $display("FAIL b2b_gap got=%b exp=01", {cfg_if.cfg_resp_valid, cfg_if.cfg_ready}); end
    @(negedge clk);
    cfg_if.cfg_valid = 1'b0;
    checks++; if ({cfg_if.cfg_resp_valid, cfg_if.cfg_resp_err, upd_en} !== 3'b101) begin errors++; $display("FAIL b2b_second got=%b exp=101", {cfg_if.cfg_resp_valid, cfg_if.cfg_resp_err, upd_en}); end
    do_reset();
  endtask

  initial begin
    rst = 1'b1; deny = 1'b0; deny_addr = 32'h0;
    cfg_if.cfg_valid = 1'b0; cfg_if.cfg_op = 3'd0; cfg_if.cfg_data = 32'h0; cfg_if.cfg_priv = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    test_reset();
    test_unlock();
    test_bad_key();
    test_escalation();
    test_priv_illegal();
    test_violations();
    test_boundary();
    do_reset();
    test_reset_mid();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

endmodule
